// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and helpers for SRAM port schedulers
package sram_ctrl_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest requester id carried in the read-return pipe.
    localparam int ID_W_MAX = 8;

    // Requester id width: log2 of the requester count, never below one bit.
    function automatic int id_width(input int num_req);
        return (num_req > 2) ? $clog2(num_req) : 1;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [ID_W_MAX-1:0] id;
    } rd_pipe_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and rotating pointer
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               en_in,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] gnt_out,
    output logic [ID_W-1:0]    gnt_id_out,
    output logic               accept_out
);

    logic [ID_W-1:0] ptr_q;

    // Scan requesters starting at the pointer; ptr+k covers 0..2N-2, so a
    // lane matches either directly or after one wrap.
    always_comb begin
        gnt_out    = '0;
        gnt_id_out = '0;
        accept_out = 1'b0;
        if (en_in) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!accept_out && req_in[i] &&
                        ((int'(ptr_q) + k == i) || (int'(ptr_q) + k == i + NUM_REQ))) begin
                        accept_out = 1'b1;
                        gnt_out[i] = 1'b1;
                        gnt_id_out = ID_W'(i);
                    end
                end
            end
        end
    end

    // Pointer moves just past the winner on accept, wrapping at NUM_REQ-1.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ptr_q <= '0;
        end else if (accept_out) begin
            ptr_q <= (gnt_id_out == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_out + 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_sched.sv
// rtl/sram_port_sched.sv - one-port SRAM scheduler with zero-fill and round-robin access
module sram_port_sched
    import sram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 5,
    parameter int INIT_EN = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ-1:0]        we_in,
    input  logic [NUM_REQ*AWIDTH-1:0] addr_in,
    input  logic [NUM_REQ*DWIDTH-1:0] wdata_in,
    output logic [NUM_REQ-1:0]        gnt_out,
    output logic [NUM_REQ-1:0]        rvalid_out,
    output logic [DWIDTH-1:0]         rdata_out,
    output logic                      init_done_out,
    output logic                      sram_en_out,
    output logic                      sram_we_out,
    output logic [AWIDTH-1:0]         sram_addr_out,
    output logic [DWIDTH-1:0]         sram_d_out,
    input  logic [DWIDTH-1:0]         sram_d_in
);

    localparam int     ID_W      = id_width(NUM_REQ);
    localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    state_t            state_q;
    state_t            state_d;
    logic [AWIDTH-1:0] cnt_q;
    logic              arb_en;
    logic              accept;
    logic [ID_W-1:0]   arb_gnt_id;
    logic              win_we;
    logic [AWIDTH-1:0] win_addr;
    logic [DWIDTH-1:0] win_wdata;
    rd_pipe_t          rd_s1_q;
    rd_pipe_t          rd_s2_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .en_in      (arb_en),
        .req_in     (req_in),
        .gnt_out    (gnt_out),
        .gnt_id_out (arb_gnt_id),
        .accept_out (accept)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave INIT once the command for the last address has been registered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (cnt_q == '1) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = RST_STATE;
        endcase
    end

    // FSM outputs: arbitration only in RUN, never while reset is held.
    always_comb begin
        arb_en        = (state_q == ST_RUN) && rst_n_in;
        init_done_out = (state_q == ST_RUN) && rst_n_in;
    end

    // Zero-fill address counter, advancing once per INIT cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // One-hot mux of the winning requester's command fields.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_out[i]) begin
                win_we    = we_in[i];
                win_addr  = addr_in[i*AWIDTH +: AWIDTH];
                win_wdata = wdata_in[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Registered SRAM command: zero-fill writes in INIT, accepted accesses in RUN.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sram_en_out   <= 1'b0;
            sram_we_out   <= 1'b0;
            sram_addr_out <= '0;
            sram_d_out    <= '0;
        end else if (state_q == ST_INIT) begin
            sram_en_out   <= 1'b1;
            sram_we_out   <= 1'b1;
            sram_addr_out <= cnt_q;
            sram_d_out    <= '0;
        end else if (accept) begin
            sram_en_out   <= 1'b1;
            sram_we_out   <= win_we;
            sram_addr_out <= win_addr;
            sram_d_out    <= win_wdata;
        end else begin
            sram_en_out   <= 1'b0;
        end
    end

    // Read-return pipe: stage 1 lines up with the command, stage 2 with SRAM data.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rd_s1_q <= '0;
            rd_s2_q <= '0;
        end else begin
            rd_s1_q.valid <= accept & ~win_we;
            rd_s1_q.id    <= ID_W_MAX'(arb_gnt_id);
            rd_s2_q       <= rd_s1_q;
        end
    end

    // Decode the returning id into a one-hot valid; data passes straight through.
    always_comb begin
        rvalid_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rvalid_out[i] = rd_s2_q.valid && (rd_s2_q.id == ID_W_MAX'(i));
        end
        rdata_out = sram_d_in;
    end

endmodule
